// File: rtl/key_table_pkg.sv
// Shared types for the key table lookup block.
// Op encodings, FSM states and the stored entry layout.
package key_table_pkg;

    localparam int DEF_KEY_W  = 128;
    localparam int DEF_DATA_W = 32;
    localparam int ENTRY_W    = 1 + DEF_KEY_W + DEF_DATA_W;

    typedef enum logic [1:0] {
        OP_LOOKUP = 2'b00,
        OP_INSERT = 2'b01,
        OP_DELETE = 2'b10,
        OP_RSVD   = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_CMP,
        S_WRITE,
        S_RESP
    } state_e;

    typedef struct packed {
        logic                  valid;
        logic [DEF_KEY_W-1:0]  key;
        logic [DEF_DATA_W-1:0] data;
    } entry_t;

endpackage

// File: rtl/key_table_fsm.sv
// Sequencer for the key table: read, wait, compare, write, respond.
// Owns the read-latency counter and all memory/response strobes.
module key_table_fsm
    import key_table_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    input  logic [1:0] req_op,
    input  logic [1:0] op_r,
    input  logic       hit,
    input  logic       entry_valid,
    output state_e     state,
    output logic       req_ready,
    output logic       capture,
    output logic       mem_rd_en,
    output logic       mem_wr_en,
    output logic       rsp_valid,
    output logic       rsp_err,
    output logic       drop_err
);

    localparam logic [2:0] LAST = 3'(RD_LAT - 1);

    logic [2:0] cnt;

    assign req_ready = (state == S_IDLE);
    assign capture   = (state == S_WAIT) && (cnt == LAST);

    // State sequencing with registered one-cycle strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            mem_rd_en <= 1'b0;
            mem_wr_en <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            drop_err  <= 1'b0;
        end else begin
            mem_rd_en <= 1'b0;
            mem_wr_en <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            if (req_valid && state != S_IDLE) begin
                drop_err <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        if (req_op == OP_RSVD) begin
                            state     <= S_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                        end else begin
                            state     <= S_READ;
                            mem_rd_en <= 1'b1;
                        end
                    end
                end
                S_READ: begin
                    state <= S_WAIT;
                    cnt   <= '0;
                end
                S_WAIT: begin
                    if (cnt == LAST) begin
                        state <= S_CMP;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                S_CMP: begin
                    case (op_r)
                        OP_INSERT: begin
                            if (!entry_valid || hit) begin
                                state     <= S_WRITE;
                                mem_wr_en <= 1'b1;
                            end else begin
                                state     <= S_RESP;
                                rsp_valid <= 1'b1;
                                rsp_err   <= 1'b1;
                            end
                        end
                        OP_DELETE: begin
                            if (hit) begin
                                state     <= S_WRITE;
                                mem_wr_en <= 1'b1;
                            end else begin
                                state     <= S_RESP;
                                rsp_valid <= 1'b1;
                            end
                        end
                        default: begin
                            state     <= S_RESP;
                            rsp_valid <= 1'b1;
                        end
                    endcase
                end
                S_WRITE: begin
                    state     <= S_RESP;
                    rsp_valid <= 1'b1;
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/key_table_lookup.sv
// Single-entry-per-bucket key table: lookup, insert, delete.
// Holds request/entry registers and the full-width key comparator.
module key_table_lookup
    import key_table_pkg::*;
#(
    parameter int ADDR_W = 20,
    parameter int KEY_W  = DEF_KEY_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int RD_LAT = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [1:0]                 req_op,
    input  logic [ADDR_W-1:0]          req_addr,
    input  logic [KEY_W-1:0]           req_key,
    input  logic [DATA_W-1:0]          req_data,
    output logic                       mem_rd_en,
    output logic [ADDR_W-1:0]          mem_rd_addr,
    input  logic [KEY_W+DATA_W:0]      mem_rd_data,
    output logic                       mem_wr_en,
    output logic [ADDR_W-1:0]          mem_wr_addr,
    output logic [KEY_W+DATA_W:0]      mem_wr_data,
    output logic                       rsp_valid,
    output logic                       rsp_hit,
    output logic                       rsp_err,
    output logic [DATA_W-1:0]          rsp_data,
    output logic                       drop_err
);

    localparam int EW = 1 + KEY_W + DATA_W;

    logic [1:0]        op_r;
    logic [ADDR_W-1:0] addr_r;
    logic [KEY_W-1:0]  key_r;
    logic [DATA_W-1:0] data_r;
    logic [EW-1:0]     entry_r;
    logic              hit_r;
    logic              hit;
    logic              capture;
    logic              accept;
    state_e            state;

    wire              entry_valid = entry_r[EW-1];
    wire [KEY_W-1:0]  entry_key   = entry_r[EW-2 -: KEY_W];
    wire [DATA_W-1:0] entry_data  = entry_r[DATA_W-1:0];

    assign accept = req_valid && req_ready;
    assign hit    = entry_valid && (entry_key == key_r);

    key_table_fsm #(
        .RD_LAT(RD_LAT)
    ) u_fsm (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_op     (req_op),
        .op_r       (op_r),
        .hit        (hit),
        .entry_valid(entry_valid),
        .state      (state),
        .req_ready  (req_ready),
        .capture    (capture),
        .mem_rd_en  (mem_rd_en),
        .mem_wr_en  (mem_wr_en),
        .rsp_valid  (rsp_valid),
        .rsp_err    (rsp_err),
        .drop_err   (drop_err)
    );

    // Request capture, RAM entry capture and registered compare result.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_r    <= '0;
            addr_r  <= '0;
            key_r   <= '0;
            data_r  <= '0;
            entry_r <= '0;
            hit_r   <= 1'b0;
        end else begin
            if (accept) begin
                op_r   <= req_op;
                addr_r <= req_addr;
                key_r  <= req_key;
                data_r <= req_data;
                hit_r  <= 1'b0;
            end
            if (capture) begin
                entry_r <= mem_rd_data;
            end
            if (state == S_CMP) begin
                hit_r <= hit;
            end
        end
    end

    assign mem_rd_addr = addr_r;
    assign mem_wr_addr = addr_r;
    assign mem_wr_data = (mem_wr_en && op_r == OP_INSERT)
                       ? {1'b1, key_r, data_r} : '0;
    assign rsp_hit     = rsp_valid && hit_r;
    assign rsp_data    = (rsp_valid && hit_r) ? entry_data : '0;

endmodule

// File: tb/tb_key_table_lookup.sv
// Bench for key_table_lookup: directed cases plus randomized
// operations checked against an associative-array table model.
module tb_key_table_lookup;
    import key_table_pkg::*;

    localparam int AW = 20;
    localparam int KW = 128;
    localparam int DW = 32;
    localparam int EW = 1 + KW + DW;
    localparam logic [KW-1:0] K1 =
        128'h0123456789abcdef_fedcba9876543210;
    localparam logic [KW-1:0] K2 = K1 ^ {1'b1, 127'b0};

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]    req_op = '0;
    logic [AW-1:0] req_addr = '0;
    logic [KW-1:0] req_key = '0;
    logic [DW-1:0] req_data = '0;
    logic          v1 = 1'b0;
    logic          v3 = 1'b0;

    logic          r1_ready, r1_rd_en, r1_wr_en;
    logic          r1_rsp, r1_hit, r1_err, r1_drop;
    logic [AW-1:0] r1_rd_addr, r1_wr_addr;
    logic [EW-1:0] r1_rd_data, r1_wr_data;
    logic [DW-1:0] r1_data;

    logic          r3_ready, r3_rd_en, r3_wr_en;
    logic          r3_rsp, r3_hit, r3_err, r3_drop;
    logic [AW-1:0] r3_rd_addr, r3_wr_addr;
    logic [EW-1:0] r3_rd_data, r3_wr_data;
    logic [DW-1:0] r3_data;

    key_table_lookup #(
        .ADDR_W(AW), .KEY_W(KW), .DATA_W(DW), .RD_LAT(1)
    ) u_dut (
        .clk(clk), .reset(reset),
        .req_valid(v1), .req_ready(r1_ready),
        .req_op(req_op), .req_addr(req_addr),
        .req_key(req_key), .req_data(req_data),
        .mem_rd_en(r1_rd_en), .mem_rd_addr(r1_rd_addr),
        .mem_rd_data(r1_rd_data),
        .mem_wr_en(r1_wr_en), .mem_wr_addr(r1_wr_addr),
        .mem_wr_data(r1_wr_data),
        .rsp_valid(r1_rsp), .rsp_hit(r1_hit), .rsp_err(r1_err),
        .rsp_data(r1_data), .drop_err(r1_drop)
    );

    key_table_lookup #(
        .ADDR_W(AW), .KEY_W(KW), .DATA_W(DW), .RD_LAT(3)
    ) u_dut3 (
        .clk(clk), .reset(reset),
        .req_valid(v3), .req_ready(r3_ready),
        .req_op(req_op), .req_addr(req_addr),
        .req_key(req_key), .req_data(req_data),
        .mem_rd_en(r3_rd_en), .mem_rd_addr(r3_rd_addr),
        .mem_rd_data(r3_rd_data),
        .mem_wr_en(r3_wr_en), .mem_wr_addr(r3_wr_addr),
        .mem_wr_data(r3_wr_data),
        .rsp_valid(r3_rsp), .rsp_hit(r3_hit), .rsp_err(r3_err),
        .rsp_data(r3_data), .drop_err(r3_drop)
    );

    // RAM models: data appears exactly RD_LAT cycles after the strobe.
    logic [EW-1:0] mem1 [logic [AW-1:0]];
    logic [EW-1:0] mem3 [logic [AW-1:0]];
    logic [EW-1:0] p1 = '0;
    logic [EW-1:0] p3 [3] = '{default: '0};

    always @(posedge clk) begin
        if (r1_wr_en) mem1[r1_wr_addr] = r1_wr_data;
        if (r1_rd_en && mem1.exists(r1_rd_addr)) p1 <= mem1[r1_rd_addr];
        else p1 <= '0;
    end
    assign r1_rd_data = p1;

    always @(posedge clk) begin
        if (r3_wr_en) mem3[r3_wr_addr] = r3_wr_data;
        if (r3_rd_en && mem3.exists(r3_rd_addr)) p3[0] <= mem3[r3_rd_addr];
        else p3[0] <= '0;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign r3_rd_data = p3[2];

    // Observation mux for whichever instance a test drives.
    bit            sel3 = 1'b0;
    logic          o_ready, o_rd, o_wr, o_rsp, o_hit, o_err, o_drop;
    logic [AW-1:0] o_wr_addr;
    logic [EW-1:0] o_wr_data;
    logic [DW-1:0] o_data;
    always_comb begin
        o_ready = sel3 ? r3_ready : r1_ready;
        o_rd = sel3 ? r3_rd_en : r1_rd_en;
        o_wr = sel3 ? r3_wr_en : r1_wr_en;
        o_rsp = sel3 ? r3_rsp : r1_rsp;
        o_hit = sel3 ? r3_hit : r1_hit;
        o_err = sel3 ? r3_err : r1_err;
        o_drop = sel3 ? r3_drop : r1_drop;
        o_wr_addr = sel3 ? r3_wr_addr : r1_wr_addr;
        o_wr_data = sel3 ? r3_wr_data : r1_wr_data;
        o_data = sel3 ? r3_data : r1_data;
    end

    int n_tests = 0;
    int n_fail = 0;

    int            ob_lat, ob_rd_n, ob_rd_cyc, ob_wr_n, ob_wr_cyc, ob_wait;
    logic          ob_hit, ob_err;
    logic [DW-1:0] ob_data;
    logic [AW-1:0] ob_wr_addr;
    logic [EW-1:0] ob_wr_data;

    // Reference table, updated from the operation rules directly.
    logic [EW-1:0] ref_tab [logic [AW-1:0]];

    function automatic void model(
        input logic [1:0] op, input logic [AW-1:0] addr,
        input logic [KW-1:0] key, input logic [DW-1:0] data,
        output bit hit, output bit err, output bit wr,
        output logic [DW-1:0] rdata, output logic [EW-1:0] wdata);
        entry_t e;
        e = ref_tab.exists(addr) ? ref_tab[addr] : '0;
        hit = e.valid && (e.key == key);
        err = 1'b0;
        wr = 1'b0;
        wdata = '0;
        if (op == OP_INSERT) begin
            if (!e.valid || hit) begin
                wr = 1'b1;
                wdata = {1'b1, key, data};
            end else begin
                err = 1'b1;
            end
        end else if (op == OP_DELETE) begin
            wr = hit;
        end else if (op == OP_RSVD) begin
            hit = 1'b0;
            err = 1'b1;
        end
        if (wr) ref_tab[addr] = wdata;
        rdata = hit ? e.data : '0;
    endfunction

    // Issue one request once ready and record what comes back.
    task automatic do_req(input bit s3, input logic [1:0] op,
                          input logic [AW-1:0] addr,
                          input logic [KW-1:0] key,
                          input logic [DW-1:0] data,
                          input int pulse_at);
        sel3 = s3;
        ob_lat = 0; ob_rd_n = 0; ob_rd_cyc = 0;
        ob_wr_n = 0; ob_wr_cyc = 0; ob_wait = 0;
        ob_hit = 1'b0; ob_err = 1'b0; ob_data = '0;
        ob_wr_addr = '0; ob_wr_data = '0;
        #1;
        while (!o_ready && ob_wait < 30) begin
            @(negedge clk);
            ob_wait++;
        end
        if (!o_ready) return;
        req_op = op; req_addr = addr; req_key = key; req_data = data;
        if (s3) v3 = 1'b1; else v1 = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (o_rd) begin
                ob_rd_n++;
                if (ob_rd_n == 1) ob_rd_cyc = k;
            end
            if (o_wr) begin
                ob_wr_n++;
                ob_wr_cyc = k;
                ob_wr_addr = o_wr_addr;
                ob_wr_data = o_wr_data;
            end
            v1 = 1'b0; v3 = 1'b0;
            if (k == pulse_at) begin
                req_op = OP_INSERT;
                req_addr = addr ^ 20'h1;
                if (s3) v3 = 1'b1; else v1 = 1'b1;
            end
            if (o_rsp) begin
                ob_lat = k; ob_hit = o_hit;
                ob_err = o_err; ob_data = o_data;
                break;
            end
        end
        v1 = 1'b0; v3 = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        sel3 = 1'b0;
        #1;
        n_tests++;
        if (o_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready got %b want 1", o_ready);
        end
        n_tests++;
        if ({o_rd, o_wr, o_rsp, o_hit, o_err, o_drop} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_strobes got %b want 000000",
                     {o_rd, o_wr, o_rsp, o_hit, o_err, o_drop});
        end
        n_tests++;
        if (o_data !== '0 || o_wr_data !== '0) begin
            n_fail++;
            $display("FAIL reset_data got %h/%h want 0", o_data, o_wr_data);
        end
    endtask

    task automatic test_directed();
        logic [1:0]    t_op [9] = '{OP_LOOKUP, OP_INSERT, OP_LOOKUP,
                                    OP_INSERT, OP_LOOKUP, OP_DELETE,
                                    OP_LOOKUP, OP_RSVD, OP_DELETE};
        logic [KW-1:0] t_key [9] = '{K1, K1, K1, K2, K1, K1, K1, K1, K1};
        int            t_lat [9] = '{4, 5, 4, 4, 4, 5, 4, 1, 4};
        bit            t_hit [9] = '{0, 0, 1, 0, 1, 1, 0, 0, 0};
        bit            t_err [9] = '{0, 0, 0, 1, 0, 0, 0, 1, 0};
        bit            t_wr  [9] = '{0, 1, 0, 0, 0, 1, 0, 0, 0};
        bit            t_bf  [9] = '{0, 0, 1, 0, 1, 1, 0, 0, 0};
        logic [EW-1:0] wd;
        logic [DW-1:0] want_d;
        for (int i = 0; i < 9; i++) begin
            do_req(1'b0, t_op[i], 20'h000A5, t_key[i],
                   (i == 3) ? 32'h12345678 : 32'hDEADBEEF, 0);
            want_d = t_bf[i] ? 32'hDEADBEEF : 32'h0;
            wd = (t_op[i] == OP_INSERT) ? {1'b1, K1, 32'hDEADBEEF} : '0;
            n_tests++;
            if (ob_lat !== t_lat[i] || ob_hit !== t_hit[i] ||
                ob_err !== t_err[i] || ob_data !== want_d) begin
                n_fail++;
                $display("FAIL dir%0d_rsp got lat%0d h%b e%b d%h want lat%0d h%b e%b d%h",
                         i, ob_lat, ob_hit, ob_err, ob_data,
                         t_lat[i], t_hit[i], t_err[i], want_d);
            end
            n_tests++;
            if (ob_wr_n !== int'(t_wr[i]) ||
                (t_wr[i] && (ob_wr_cyc !== t_lat[i] - 1 ||
                 ob_wr_addr !== 20'h000A5 || ob_wr_data !== wd))) begin
                n_fail++;
                $display("FAIL dir%0d_wr got n%0d c%0d a%h d%h want n%0d c%0d d%h",
                         i, ob_wr_n, ob_wr_cyc, ob_wr_addr, ob_wr_data,
                         t_wr[i], t_lat[i] - 1, wd);
            end
            n_tests++;
            if (ob_rd_n !== ((t_op[i] == OP_RSVD) ? 0 : 1) ||
                (t_op[i] != OP_RSVD && ob_rd_cyc !== 1)) begin
                n_fail++;
                $display("FAIL dir%0d_rd got n%0d c%0d", i, ob_rd_n, ob_rd_cyc);
            end
            if (i == 3) begin
                n_tests++;
                if (mem1[20'h000A5] !== {1'b1, K1, 32'hDEADBEEF}) begin
                    n_fail++;
                    $display("FAIL collide_keep got %h", mem1[20'h000A5]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] addrs [4] = '{20'h00000, 20'hFFFFF,
                                     20'h000A5, 20'h70001};
        logic [KW-1:0] keys [3];
        logic [1:0]    op;
        logic [AW-1:0] a;
        logic [KW-1:0] k;
        logic [DW-1:0] d, e_d;
        logic [EW-1:0] e_wd, got;
        bit            e_h, e_e, e_w;
        int            r, e_lat;
        keys[0] = K1; keys[1] = K2;
        keys[2] = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 9);
            op = (r < 4) ? OP_LOOKUP : (r < 7) ? OP_INSERT :
                 (r < 9) ? OP_DELETE : OP_RSVD;
            a = addrs[$urandom_range(0, 3)];
            k = keys[$urandom_range(0, 2)];
            d = $urandom;
            model(op, a, k, d, e_h, e_e, e_w, e_d, e_wd);
            e_lat = (op == OP_RSVD) ? 1 : (e_w ? 5 : 4);
            do_req(1'b0, op, a, k, d, 0);
            n_tests++;
            if (ob_lat !== e_lat || ob_hit !== e_h ||
                ob_err !== e_e || ob_data !== e_d) begin
                n_fail++;
                $display("FAIL rnd%0d_rsp op%0d got lat%0d h%b e%b d%h want lat%0d h%b e%b d%h",
                         i, op, ob_lat, ob_hit, ob_err, ob_data,
                         e_lat, e_h, e_e, e_d);
            end
            n_tests++;
            if (ob_wr_n !== int'(e_w) ||
                (e_w && (ob_wr_addr !== a || ob_wr_data !== e_wd))) begin
                n_fail++;
                $display("FAIL rnd%0d_wr got n%0d a%h d%h want n%0d a%h d%h",
                         i, ob_wr_n, ob_wr_addr, ob_wr_data, e_w, a, e_wd);
            end
            if (i > 0) begin
                n_tests++;
                if (ob_wait !== 1) begin
                    n_fail++;
                    $display("FAIL rnd%0d_ready_gap got %0d want 1", i, ob_wait);
                end
            end
        end
        for (int j = 0; j < 4; j++) begin
            got = mem1.exists(addrs[j]) ? mem1[addrs[j]] : '0;
            e_wd = ref_tab.exists(addrs[j]) ? ref_tab[addrs[j]] : '0;
            n_tests++;
            if (got !== e_wd) begin
                n_fail++;
                $display("FAIL ram_%h got %h want %h", addrs[j], got, e_wd);
            end
        end
        n_tests++;
        if (o_drop !== 1'b0) begin
            n_fail++; $display("FAIL b2b_drop got %b want 0", o_drop);
        end
    endtask

    task automatic test_rdlat3();
        do_req(1'b1, OP_LOOKUP, 20'h00300, K1, 32'h0, 0);
        n_tests++;
        if (ob_lat !== 6 || ob_hit !== 1'b0 || ob_wr_n !== 0) begin
            n_fail++;
            $display("FAIL lat3_lookup got lat%0d h%b w%0d want 6 0 0",
                     ob_lat, ob_hit, ob_wr_n);
        end
        do_req(1'b1, OP_INSERT, 20'h00300, K1, 32'hCAFEF00D, 0);
        n_tests++;
        if (ob_lat !== 7 || ob_wr_cyc !== 6 ||
            ob_wr_data !== {1'b1, K1, 32'hCAFEF00D}) begin
            n_fail++;
            $display("FAIL lat3_insert got lat%0d wc%0d d%h want 7 6",
                     ob_lat, ob_wr_cyc, ob_wr_data);
        end
        do_req(1'b1, OP_LOOKUP, 20'h00300, K1, 32'h0, 0);
        n_tests++;
        if (ob_lat !== 6 || ob_hit !== 1'b1 || ob_data !== 32'hCAFEF00D) begin
            n_fail++;
            $display("FAIL lat3_hit got lat%0d h%b d%h want 6 1 cafef00d",
                     ob_lat, ob_hit, ob_data);
        end
        sel3 = 1'b0;
    endtask

    task automatic test_drop();
        do_req(1'b0, OP_LOOKUP, 20'h00123, K1, 32'h0, 2);
        n_tests++;
        if (ob_lat !== 4 || ob_hit !== 1'b0 || ob_err !== 1'b0 ||
            ob_wr_n !== 0) begin
            n_fail++;
            $display("FAIL drop_rsp got lat%0d h%b e%b w%0d want 4 0 0 0",
                     ob_lat, ob_hit, ob_err, ob_wr_n);
        end
        n_tests++;
        if (o_drop !== 1'b1) begin
            n_fail++; $display("FAIL drop_set got %b want 1", o_drop);
        end
        do_req(1'b0, OP_LOOKUP, 20'h00122, K1, 32'h0, 0);
        n_tests++;
        if (o_drop !== 1'b1 || ob_hit !== 1'b0 || ob_lat !== 4) begin
            n_fail++;
            $display("FAIL drop_sticky got d%b h%b lat%0d want 1 0 4",
                     o_drop, ob_hit, ob_lat);
        end
    endtask

    task automatic test_reset_mid();
        int wr_n, rsp_n;
        sel3 = 1'b0;
        wr_n = 0; rsp_n = 0;
        req_op = OP_INSERT; req_addr = 20'h00456;
        req_key = K2; req_data = 32'h55AA55AA;
        v1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        v1 = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_tests++;
        if (o_ready !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_ready got %b want 1", o_ready);
        end
        for (int k = 0; k < 10; k++) begin
            if (o_wr) wr_n++;
            if (o_rsp) rsp_n++;
            @(negedge clk);
        end
        n_tests++;
        if (wr_n !== 0 || rsp_n !== 0) begin
            n_fail++;
            $display("FAIL rstmid_quiet got wr%0d rsp%0d want 0 0", wr_n, rsp_n);
        end
        n_tests++;
        if (o_drop !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_drop got %b want 0", o_drop);
        end
        do_req(1'b0, OP_LOOKUP, 20'h00456, K2, 32'h0, 0);
        n_tests++;
        if (ob_lat !== 4 || ob_hit !== 1'b0 || ob_data !== 32'h0) begin
            n_fail++;
            $display("FAIL rstmid_after got lat%0d h%b d%h want 4 0 0",
                     ob_lat, ob_hit, ob_data);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_rdlat3();
        test_drop();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
